// File: rtl/splitter_stack_lock_arbiter.sv
// Round-robin lock arbiter guarding the tile splitter stack, with a one-cycle turnover gap.
// Defining SPLITTER_STACK_LOCK_WATCHDOG_EN adds a hold-time watchdog that revokes a stuck lock.
module splitter_stack_lock_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_LOG = 10,
    localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,      // release pulse; 'release' is a reserved word
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [ID_W-1:0]    owner_id,
    output logic [15:0]        hold_cycles,
    input  logic               clear_stats,
    output logic [31:0]        num_grants,
    output logic [31:0]        num_contended,
    output logic               err_bad_release,
    output logic               timeout,
    output logic [ID_W-1:0]    timeout_id
);

    typedef enum logic [1:0] {IDLE, GRANTED, HANDOFF} state_t;

    localparam logic [15:0] HOLD_MAX = 16'hFFFF;

    if (TIMEOUT_LOG < 4 || TIMEOUT_LOG > 16) begin : g_bad_timeout_log
        $error("TIMEOUT_LOG must lie in 4..16");
    end

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [NUM_REQ-1:0] owner_mask;
    logic [ID_W-1:0]    owner_next;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    rr_ptr;
    logic [15:0]        hold_next;
    logic               issue;
    logic               own_rel;
    logic               bad_rel;
    logic               contended;

`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'((32'd1 << TIMEOUT_LOG) - 32'd1);
    logic wd_fire;
`endif

    assign owner_mask = NUM_REQ'(1) << owner_id;
    assign rr_ptr     = (32'(owner_id) == NUM_REQ - 1) ? '0 : owner_id + ID_W'(1);
    assign own_rel    = |(rel & grant);
    assign bad_rel    = |(rel & ~owner_mask);
    assign contended  = busy && |(req & ~owner_mask);

    // Round-robin pick; scanning backwards lets the nearest requester to rr_ptr win.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = rr_ptr;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            idx = (32'(rr_ptr) + i - 1) % NUM_REQ;
            if (req[ID_W'(idx)]) begin
                pick = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        owner_next = owner_id;
        hold_next  = hold_cycles;
        issue      = 1'b0;
`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
        wd_fire    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_next = GRANTED;
                    grant_next = NUM_REQ'(1) << pick;
                    owner_next = pick;
                    hold_next  = '0;
                    issue      = 1'b1;
                end
            end
            GRANTED: begin
                if (hold_cycles != HOLD_MAX) begin
                    hold_next = hold_cycles + 16'd1;
                end
                if (own_rel) begin
                    state_next = HANDOFF;
                    grant_next = '0;
                end
`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
                else if (hold_cycles == WD_LIMIT) begin
                    state_next = HANDOFF;
                    grant_next = '0;
                    wd_fire    = 1'b1;
                end
`endif
            end
            HANDOFF: begin
                state_next = IDLE;
                grant_next = '0;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            owner_id    <= ID_W'(NUM_REQ - 1);
            hold_cycles <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            busy        <= (state_next != IDLE);
            owner_id    <= owner_next;
            hold_cycles <= hold_next;
        end
    end

    // Statistics and sticky error; clear_stats wins over same-cycle events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_grants      <= '0;
            num_contended   <= '0;
            err_bad_release <= 1'b0;
        end else if (clear_stats) begin
            num_grants      <= '0;
            num_contended   <= '0;
            err_bad_release <= 1'b0;
        end else begin
            if (issue) begin
                num_grants <= num_grants + 32'd1;
            end
            if (contended) begin
                num_contended <= num_contended + 32'd1;
            end
            if (bad_rel) begin
                err_bad_release <= 1'b1;
            end
        end
    end

`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timeout    <= 1'b0;
            timeout_id <= '0;
        end else if (clear_stats) begin
            timeout    <= 1'b0;
            timeout_id <= '0;
        end else if (wd_fire) begin
            timeout    <= 1'b1;
            timeout_id <= owner_id;
        end
    end
`else
    assign timeout    = 1'b0;
    assign timeout_id = '0;
`endif

endmodule

// File: tb/tb_splitter_stack_lock_arbiter.sv
// Self-checking bench for splitter_stack_lock_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural lock model.
module tb_splitter_stack_lock_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned TL = 4;
    localparam int unsigned IW = 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rel = '0;
    logic          clear_stats = 1'b0;
    logic [N-1:0]  grant;
    logic          busy;
    logic [IW-1:0] owner_id;
    logic [15:0]   hold_cycles;
    logic [31:0]   num_grants;
    logic [31:0]   num_contended;
    logic          err_bad_release;
    logic          timeout;
    logic [IW-1:0] timeout_id;

    always #5 clk = ~clk;

    splitter_stack_lock_arbiter #(.NUM_REQ(N), .TIMEOUT_LOG(TL)) dut (
        .clk(clk), .rstn(rstn), .req(req), .rel(rel), .grant(grant), .busy(busy),
        .owner_id(owner_id), .hold_cycles(hold_cycles), .clear_stats(clear_stats),
        .num_grants(num_grants), .num_contended(num_contended),
        .err_bad_release(err_bad_release), .timeout(timeout), .timeout_id(timeout_id)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Behavioural model: who holds the lock (-1 = free), whether the turnover gap is pending.
    int          m_holder;
    bit          m_gap;
    int          m_last;
    logic [15:0] m_hold;
    logic [31:0] m_grants;
    logic [31:0] m_cont;
    bit          m_err;
    bit          m_to;
    int          m_toid;

    task automatic m_reset();
        m_holder = -1; m_gap = 1'b0; m_last = N - 1; m_hold = '0;
        m_grants = '0; m_cont = '0; m_err = 1'b0; m_to = 1'b0; m_toid = 0;
    endtask

    function automatic logic [N-1:0] m_grant();
        return (m_holder >= 0) ? (N'(1) << m_holder) : '0;
    endfunction

    task automatic m_step();
        bit          was_busy, bad, cont, issued, fired;
        int          fired_id;
        logic [15:0] old_hold;
        was_busy = (m_holder >= 0) || m_gap;
        bad = 1'b0; cont = 1'b0; issued = 1'b0; fired = 1'b0; fired_id = 0;
        for (int j = 0; j < N; j++) begin
            if (j != m_last && rel[IW'(j)]) bad = 1'b1;
            if (j != m_last && req[IW'(j)] && was_busy) cont = 1'b1;
        end
        if (m_holder < 0 && !m_gap) begin
            for (int k = 1; k <= N; k++) begin
                int w;
                w = (m_last + k) % N;
                if (req[IW'(w)]) begin
                    m_holder = w; m_last = w; m_hold = '0; issued = 1'b1;
                    break;
                end
            end
        end else if (m_holder >= 0) begin
            old_hold = m_hold;
            if (m_hold != 16'hFFFF) m_hold = m_hold + 16'd1;
            if (rel[IW'(m_holder)]) begin
                m_holder = -1; m_gap = 1'b1;
            end
`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
            else if (int'(old_hold) == (1 << TL) - 1) begin
                fired = 1'b1; fired_id = m_holder; m_holder = -1; m_gap = 1'b1;
            end
`endif
        end else begin
            m_gap = 1'b0;
        end
        if (clear_stats) begin
            m_grants = '0; m_cont = '0; m_err = 1'b0; m_to = 1'b0; m_toid = 0;
        end else begin
            if (issued) m_grants = m_grants + 32'd1;
            if (cont) m_cont = m_cont + 32'd1;
            if (bad) m_err = 1'b1;
            if (fired) begin m_to = 1'b1; m_toid = fired_id; end
        end
    endtask

    // Advance one clock; model follows the edge, outputs are then sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        m_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = '0; rel = '0; clear_stats = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (owner_id !== 1'b1) begin fails++; $display("FAIL reset_owner got %0d exp 1", owner_id); end
        checks++; if (hold_cycles !== 16'd0) begin fails++; $display("FAIL reset_hold got %0d exp 0", hold_cycles); end
        checks++; if (num_grants !== 32'd0 || num_contended !== 32'd0) begin fails++; $display("FAIL reset_counters got %0d/%0d exp 0/0", num_grants, num_contended); end
        checks++; if (err_bad_release !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL reset_flags got %b/%b exp 0/0", err_bad_release, timeout); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin fails++; $display("FAIL single_grant got %b exp 01", grant); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++; if (num_grants !== 32'd1) begin fails++; $display("FAIL single_num_grants got %0d exp 1", num_grants); end
        checks++; if (owner_id !== 1'b0) begin fails++; $display("FAIL single_owner got %0d exp 0", owner_id); end
        tick(); tick();
        checks++; if (hold_cycles !== 16'd2) begin fails++; $display("FAIL single_hold got %0d exp 2", hold_cycles); end
        rel = 2'b01; req = 2'b00;
        tick();
        rel = 2'b00;
        checks++; if (grant !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL single_handoff got grant %b busy %b exp 00 1", grant, busy); end
        tick();
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL single_idle got grant %b busy %b exp 00 0", grant, busy); end
        checks++; if (num_contended !== 32'd0) begin fails++; $display("FAIL single_contended got %0d exp 0", num_contended); end
    endtask

    task automatic test_alternate();
        int e;
        logic [N-1:0] exp_g;
        e = 1;
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g = N'(1) << e;
            tick();
            checks++; if (grant !== exp_g) begin fails++; $display("FAIL alt_grant round %0d got %b exp %b", r, grant, exp_g); end
            tick(); tick();
            rel = exp_g;
            tick();
            rel = '0;
            checks++; if (grant !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL alt_gap round %0d got %b/%b exp 00/1", r, grant, busy); end
            tick();
            checks++; if (grant !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL alt_idle round %0d got %b/%b exp 00/0", r, grant, busy); end
            e = 1 - e;
        end
        req = '0;
        checks++; if (num_contended !== m_cont) begin fails++; $display("FAIL alt_contended got %0d exp %0d", num_contended, m_cont); end
        checks++; if (num_grants !== 32'd5) begin fails++; $display("FAIL alt_num_grants got %0d exp 5", num_grants); end
    endtask

    task automatic test_bad_release_clear();
        req = 2'b10;
        tick();
        checks++; if (grant !== 2'b10) begin fails++; $display("FAIL bad_pre_grant got %b exp 10", grant); end
        rel = 2'b01;
        tick();
        rel = '0;
        checks++; if (grant !== 2'b10) begin fails++; $display("FAIL bad_grant_kept got %b exp 10", grant); end
        checks++; if (err_bad_release !== 1'b1) begin fails++; $display("FAIL bad_err_set got %b exp 1", err_bad_release); end
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checks++; if (err_bad_release !== 1'b0 || num_grants !== 32'd0) begin fails++; $display("FAIL clear_stats got err %b grants %0d exp 0 0", err_bad_release, num_grants); end
        checks++; if (grant !== 2'b10) begin fails++; $display("FAIL clear_grant got %b exp 10", grant); end
        rel = 2'b10; req = '0;
        tick();
        rel = '0;
        tick();
    endtask

    task automatic test_release_with_req();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin fails++; $display("FAIL relreq_first got %b exp 01", grant); end
        req = 2'b11;
        tick();
        rel = 2'b01;
        tick();
        rel = '0;
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL relreq_drop got %b exp 00", grant); end
        tick(); tick();
        checks++; if (grant !== 2'b10) begin fails++; $display("FAIL relreq_next got %b exp 10", grant); end
        rel = 2'b10; req = '0;
        tick();
        rel = '0;
        tick();
    endtask

    task automatic test_long_hold();
        req = 2'b01;
        tick();
        req = '0;
`ifdef SPLITTER_STACK_LOCK_WATCHDOG_EN
        begin
            int t;
            t = 0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                t = k;
                if (grant === 2'b00) break;
            end
            checks++; if (t != 16) begin fails++; $display("FAIL wd_drop_cycle got %0d exp 16", t); end
            checks++; if (timeout !== 1'b1 || timeout_id !== 1'b0) begin fails++; $display("FAIL wd_flags got %b id %0d exp 1 id 0", timeout, timeout_id); end
            tick();
        end
`else
        repeat (100) tick();
        checks++; if (grant !== 2'b01) begin fails++; $display("FAIL hold_grant got %b exp 01", grant); end
        checks++; if (hold_cycles !== 16'd100) begin fails++; $display("FAIL hold_count got %0d exp 100", hold_cycles); end
        checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL hold_timeout got %b exp 0", timeout); end
        rel = 2'b01;
        tick();
        rel = '0;
        tick();
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            int r;
            req = N'($urandom);
            r = int'($urandom_range(0, 7));
            if (r < 2) rel = N'($urandom);
            else if (r < 4) rel = m_grant();
            else rel = '0;
            clear_stats = ($urandom_range(0, 31) == 0);
            tick();
            checks++; if (grant !== m_grant()) begin fails++; $display("FAIL rnd_grant cyc %0d got %b exp %b", cyc, grant, m_grant()); end
            checks++; if (busy !== ((m_holder >= 0) || m_gap)) begin fails++; $display("FAIL rnd_busy cyc %0d got %b", cyc, busy); end
            checks++; if (owner_id !== IW'(m_last)) begin fails++; $display("FAIL rnd_owner cyc %0d got %0d exp %0d", cyc, owner_id, m_last); end
            checks++; if (hold_cycles !== m_hold) begin fails++; $display("FAIL rnd_hold cyc %0d got %0d exp %0d", cyc, hold_cycles, m_hold); end
            checks++; if (num_grants !== m_grants) begin fails++; $display("FAIL rnd_grants cyc %0d got %0d exp %0d", cyc, num_grants, m_grants); end
            checks++; if (num_contended !== m_cont) begin fails++; $display("FAIL rnd_contended cyc %0d got %0d exp %0d", cyc, num_contended, m_cont); end
            checks++; if (err_bad_release !== m_err) begin fails++; $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, err_bad_release, m_err); end
            checks++; if (timeout !== m_to || timeout_id !== IW'(m_toid)) begin fails++; $display("FAIL rnd_timeout cyc %0d got %b/%0d exp %b/%0d", cyc, timeout, timeout_id, m_to, m_toid); end
        end
        req = '0; rel = '0; clear_stats = 1'b0;
    endtask

    task automatic test_async_reset();
        rel = '1; req = '0;
        tick();
        rel = '0;
        tick(); tick();
        req = 2'b10;
        tick();
        tick();
        checks++; if (grant !== m_grant() || grant === 2'b00) begin fails++; $display("FAIL arst_pre_grant got %b exp %b", grant, m_grant()); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL arst_immediate got %b/%b exp 00/0", grant, busy); end
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
        req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin fails++; $display("FAIL arst_first_grant got %b exp 01", grant); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_bad_release_clear();
        test_release_with_req();
        test_long_hold();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
